// File: rtl/cmd_sequencer_if.sv
// RemoteComm link of the command sequencer: command word and send strobe out,
// transmit-complete and response byte back.
interface cmd_sequencer_if #(
   parameter int CMD_W = 16
);
   logic [CMD_W-1:0] cmd;
   logic             snd_cmd;
   logic             cmd_snt;
   logic             resp_rdy;
   logic [7:0]       resp;

   modport master (
      output cmd,
      output snd_cmd,
      input  cmd_snt,
      input  resp_rdy,
      input  resp
   );

   modport slave (
      input  cmd,
      input  snd_cmd,
      output cmd_snt,
      output resp_rdy,
      output resp
   );
endinterface

// File: rtl/cmd_sequencer.sv
// Command sequencer: queues command words and plays them to RemoteComm one at a
// time, waiting for transmit-complete and a positive acknowledge for each.
module cmd_sequencer #(
   parameter int          CMD_W   = 16,
   parameter int          DEPTH   = 8,
   parameter int          TMO_CYC = 1000000,
   parameter logic [7:0]  POS_ACK = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [CMD_W-1:0]       push_cmd,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   input  logic                   start,
   input  logic                   abort,
   cmd_sequencer_if.master        rc,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic [7:0]             n_acked
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TMO_CYC + 1);

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_BAD_ACK = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_ABORTED = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_SNT,
      WAIT_RESP,
      DONE,
      ERR
   } state_t;

   state_t           state;
   logic [CMD_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_r;
   logic [TW-1:0]    tmo_cnt;
   logic [CMD_W-1:0] cmd_r;
   logic             snd_cmd_r;
   logic             pop;
   logic             push_ok;
   logic             tmo_hit;

   // A full queue still takes a push when the head is popped in the same cycle.
   assign pop     = (state == LOAD) && !abort;
   assign push_ok = push && !rst && !abort && (!full || pop);
   assign full    = (count_r == CW'(DEPTH));
   assign count   = count_r;
   assign tmo_hit = (tmo_cnt == TW'(TMO_CYC - 1));

   assign rc.cmd     = cmd_r;
   assign rc.snd_cmd = snd_cmd_r;

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_cmd;
   end

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_r <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // err/err_code are raised on the edge that enters ERR; the ERR state itself
   // only drops busy and returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cmd_r     <= '0;
         snd_cmd_r <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
         n_acked   <= '0;
         tmo_cnt   <= '0;
      end else begin
         snd_cmd_r <= 1'b0;
         done      <= 1'b0;
         if (abort) begin
            if (state != IDLE) begin
               err      <= 1'b1;
               err_code <= ERR_ABORTED;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     err      <= 1'b0;
                     err_code <= ERR_NONE;
                     if (count_r != '0) begin
                        busy    <= 1'b1;
                        n_acked <= '0;
                        state   <= LOAD;
                     end else begin
                        done <= 1'b1;
                     end
                  end
               end
               LOAD: begin
                  cmd_r     <= mem[rd_ptr];
                  snd_cmd_r <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= WAIT_SNT;
               end
               WAIT_SNT: begin
                  if (rc.cmd_snt) begin
                     tmo_cnt <= '0;
                     state   <= WAIT_RESP;
                  end else if (tmo_hit) begin
                     err      <= 1'b1;
                     err_code <= ERR_TIMEOUT;
                     state    <= ERR;
                  end else begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end
               WAIT_RESP: begin
                  if (rc.resp_rdy) begin
                     if (rc.resp == POS_ACK) begin
                        if (n_acked != 8'hFF)
                           n_acked <= n_acked + 8'd1;
                        state <= (count_r != '0) ? LOAD : DONE;
                     end else begin
                        err      <= 1'b1;
                        err_code <= ERR_BAD_ACK;
                        state    <= ERR;
                     end
                  end else if (tmo_hit) begin
                     err      <= 1'b1;
                     err_code <= ERR_TIMEOUT;
                     state    <= ERR;
                  end else begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end
               DONE: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               ERR: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: plays RemoteComm by hand and compares
// every observation against hand-computed values.
module tb_cmd_sequencer;

   localparam int CMD_W   = 16;
   localparam int DEPTH   = 8;
   localparam int TMO_CYC = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        push;
   logic [15:0] push_cmd;
   logic        full;
   logic [3:0]  count;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [7:0]  n_acked;

   int vectors     = 0;
   int miscompares = 0;
   int snd_total   = 0;
   int snd_mark;

   cmd_sequencer_if #(.CMD_W(CMD_W)) rc_if ();

   cmd_sequencer #(
      .CMD_W   (CMD_W),
      .DEPTH   (DEPTH),
      .TMO_CYC (TMO_CYC),
      .POS_ACK (8'hA5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_cmd (push_cmd),
      .full     (full),
      .count    (count),
      .start    (start),
      .abort    (abort),
      .rc       (rc_if),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_code (err_code),
      .n_acked  (n_acked)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rc_if.snd_cmd)
         snd_total <= snd_total + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One cycle of control-side inputs, then back to idle levels.
   task automatic applyStimulus(input logic p, input logic [15:0] w, input logic s, input logic a);
      push     = p;
      push_cmd = w;
      start    = s;
      abort    = a;
      tick();
      push     = 1'b0;
      push_cmd = '0;
      start    = 1'b0;
      abort    = 1'b0;
   endtask

   task automatic waitSnd();
      int n = 0;
      while (!rc_if.snd_cmd && n < 50) begin
         tick();
         n++;
      end
      checkOutput("snd_wait", rc_if.snd_cmd, 1);
   endtask

   task automatic waitDone();
      int n = 0;
      while (!done && n < 50) begin
         tick();
         n++;
      end
      checkOutput("done_wait", done, 1);
   endtask

   task automatic waitErr();
      int n = 0;
      while (!err && n < 50) begin
         tick();
         n++;
      end
      checkOutput("err_wait", err, 1);
   endtask

   task automatic serveCommand(input logic [15:0] exp_cmd, input logic [7:0] rbyte);
      waitSnd();
      checkOutput("cmd", rc_if.cmd, exp_cmd);
      rc_if.cmd_snt = 1'b1;
      tick();
      rc_if.cmd_snt = 1'b0;
      checkOutput("snd_one_cycle", rc_if.snd_cmd, 0);
      checkOutput("cmd_stable", rc_if.cmd, exp_cmd);
      rc_if.resp_rdy = 1'b1;
      rc_if.resp     = rbyte;
      tick();
      rc_if.resp_rdy = 1'b0;
      rc_if.resp     = '0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_count"}, count, 0);
      checkOutput({tag, "_full"}, full, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_err"}, err, 0);
      checkOutput({tag, "_err_code"}, err_code, 0);
      checkOutput({tag, "_n_acked"}, n_acked, 0);
      checkOutput({tag, "_cmd"}, rc_if.cmd, 0);
      checkOutput({tag, "_snd_cmd"}, rc_if.snd_cmd, 0);
   endtask

   initial begin
      rst            = 1'b1;
      push           = 1'b0;
      push_cmd       = '0;
      start          = 1'b0;
      abort          = 1'b0;
      rc_if.cmd_snt  = 1'b0;
      rc_if.resp_rdy = 1'b0;
      rc_if.resp     = '0;
      tick();
      tick();
      rst = 1'b0;
      checkAllZero("reset");

      // Two commands, both acknowledged.
      applyStimulus(1'b1, 16'h47F1, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h5BF2, 1'b0, 1'b0);
      checkOutput("two_count", count, 2);
      snd_mark = snd_total;
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("two_busy", busy, 1);
      serveCommand(16'h47F1, 8'hA5);
      serveCommand(16'h5BF2, 8'hA5);
      waitDone();
      tick();
      checkOutput("two_done_pulse", done, 0);
      checkOutput("two_snd_pulses", snd_total - snd_mark, 2);
      checkOutput("two_n_acked", n_acked, 2);
      checkOutput("two_err", err, 0);
      checkOutput("two_busy_end", busy, 0);

      // Overfill, then push into the full queue while the head is popped.
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
      checkOutput("fill_full", full, 1);
      applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
      checkOutput("overfill_count", count, DEPTH);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'h2000, 1'b0, 1'b0);
      checkOutput("push_pop_full_count", count, DEPTH);
      for (int i = 0; i < DEPTH; i++)
         serveCommand(16'h1000 + 16'(i), 8'hA5);
      serveCommand(16'h2000, 8'hA5);
      waitDone();
      checkOutput("drain_n_acked", n_acked, DEPTH + 1);
      checkOutput("drain_count", count, 0);

      // Bad acknowledge on the second command leaves the third queued.
      applyStimulus(1'b1, 16'h3001, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h3002, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h3003, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      serveCommand(16'h3001, 8'hA5);
      serveCommand(16'h3002, 8'h5A);
      waitErr();
      checkOutput("badack_code", err_code, 1);
      checkOutput("badack_n_acked", n_acked, 1);
      tick();
      checkOutput("badack_busy", busy, 0);
      checkOutput("badack_count", count, 1);
      tick();
      checkOutput("badack_sticky", err, 1);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("restart_err_clear", err, 0);
      checkOutput("restart_code_clear", err_code, 0);
      serveCommand(16'h3003, 8'hA5);
      waitDone();
      checkOutput("restart_n_acked", n_acked, 1);

      // cmd_snt never arrives: timeout after TMO_CYC cycles in WAIT_SNT.
      applyStimulus(1'b1, 16'h4444, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      waitSnd();
      for (int i = 0; i < TMO_CYC - 1; i++)
         tick();
      checkOutput("tmo_not_yet", err, 0);
      tick();
      checkOutput("tmo_err", err, 1);
      checkOutput("tmo_code", err_code, 2);
      tick();
      checkOutput("tmo_busy", busy, 0);

      // Abort in WAIT_RESP beats a same-cycle push.
      applyStimulus(1'b1, 16'h5001, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h5002, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      waitSnd();
      rc_if.cmd_snt = 1'b1;
      tick();
      rc_if.cmd_snt = 1'b0;
      applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b1);
      checkOutput("abort_count", count, 0);
      checkOutput("abort_err", err, 1);
      checkOutput("abort_code", err_code, 3);
      checkOutput("abort_busy", busy, 0);
      snd_mark = snd_total;
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("abort_empty_done", done, 1);

      // Abort in IDLE only flushes.
      applyStimulus(1'b1, 16'h6001, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("idle_abort_count", count, 0);
      checkOutput("idle_abort_err", err, 0);
      checkOutput("abort_no_snd", snd_total - snd_mark, 0);

      // Reset in WAIT_SNT with three entries queued.
      applyStimulus(1'b1, 16'h7001, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h7002, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h7003, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      waitSnd();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkAllZero("midrst");
      snd_mark = snd_total;
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("midrst_done", done, 1);
      tick();
      tick();
      checkOutput("midrst_no_snd", snd_total - snd_mark, 0);
      checkOutput("midrst_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
